// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter slice.
// Mode encoding and word width used by all files.
package alu_arbiter_pkg;

    localparam int WORD_SIZE_DFLT = 16;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, ALU and response bundle of alu_arbiter.
// slave = arbiter side, master = environment side.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int WORD_SIZE = WORD_SIZE_DFLT,
    parameter int ID_W      = 2
);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*WORD_SIZE-1:0] req_a;
    logic [NUM_REQ*WORD_SIZE-1:0] req_b;
    logic [NUM_REQ-1:0]           req_mode;

    logic [WORD_SIZE-1:0] alu_a;
    logic [WORD_SIZE-1:0] alu_b;
    logic                 alu_mode;
    logic [WORD_SIZE-1:0] alu_c;
    logic                 alu_overflow;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WORD_SIZE-1:0] rsp_data;
    logic                 rsp_overflow;
    logic [ID_W-1:0]      rsp_id;

    logic ovf_clr;
    logic ovf_sticky;

    modport slave (
        input  req_valid, req_a, req_b, req_mode,
        input  alu_c, alu_overflow,
        input  rsp_ready, ovf_clr,
        output req_ready,
        output alu_a, alu_b, alu_mode,
        output rsp_valid, rsp_data, rsp_overflow, rsp_id,
        output ovf_sticky
    );

    modport master (
        output req_valid, req_a, req_b, req_mode,
        output alu_c, alu_overflow,
        output rsp_ready, ovf_clr,
        input  req_ready,
        input  alu_a, alu_b, alu_mode,
        input  rsp_valid, rsp_data, rsp_overflow, rsp_id,
        input  ovf_sticky
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first active
// request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N    = 2,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant
);

    // Scan from ptr, keep only the first hit
    always_comb begin
        int   idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external add/sub ALU between NUM_REQ
// requesters: operand stage S1, result stage S2.
import alu_arbiter_pkg::*;

module alu_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int WORD_SIZE = WORD_SIZE_DFLT,
    parameter int ID_W      = 2
) (
    input logic         clk,
    input logic         rst_n,
    alu_arbiter_if.slave bus
);

    logic                 en;
    logic                 s1_valid;
    logic [ID_W-1:0]      s1_id;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      gidx;
    logic [NUM_REQ-1:0]   grant;
    logic                 s2_take;
    logic                 s1_take;
    logic                 hs;
    logic                 s2_load;
    logic [WORD_SIZE-1:0] sel_a;
    logic [WORD_SIZE-1:0] sel_b;
    logic                 sel_mode;

    assign s2_take = !bus.rsp_valid | bus.rsp_ready;
    assign s1_take = (!s1_valid | s2_take) & en;
    assign bus.req_ready = grant & {NUM_REQ{s1_take}};
    assign hs      = |bus.req_ready;
    assign s2_load = s1_valid & s2_take;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // One-hot grant to requester index
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) gidx = ID_W'(i);
        end
    end

    assign sel_a    = bus.req_a[int'(gidx)*WORD_SIZE +: WORD_SIZE];
    assign sel_b    = bus.req_b[int'(gidx)*WORD_SIZE +: WORD_SIZE];
    assign sel_mode = bus.req_mode[gidx];

    // Accept enable, held off until reset is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) en <= 1'b0;
        else        en <= 1'b1;
    end

    // Round-robin pointer moves past the last winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  ptr <= '0;
        else if (hs) ptr <= ID_W'(wrap_inc(int'(gidx), NUM_REQ));
    end

    // S1 operand register feeding the ALU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_id        <= '0;
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_mode <= ALU_ADD;
        end else if (hs) begin
            s1_valid     <= 1'b1;
            s1_id        <= gidx;
            bus.alu_a    <= sel_a;
            bus.alu_b    <= sel_b;
            bus.alu_mode <= sel_mode;
        end else if (s2_take) begin
            s1_valid     <= 1'b0;
        end
    end

    // S2 result register with backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid    <= 1'b0;
            bus.rsp_data     <= '0;
            bus.rsp_overflow <= 1'b0;
            bus.rsp_id       <= '0;
        end else if (s2_load) begin
            bus.rsp_valid    <= 1'b1;
            bus.rsp_data     <= bus.alu_c;
            bus.rsp_overflow <= bus.alu_overflow;
            bus.rsp_id       <= s1_id;
        end else if (bus.rsp_ready) begin
            bus.rsp_valid    <= 1'b0;
        end
    end

    // Sticky overflow; a capture beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.ovf_sticky <= 1'b0;
        else if (s2_load && bus.alu_overflow)
            bus.ovf_sticky <= 1'b1;
        else if (bus.ovf_clr)
            bus.ovf_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with four
// requesters and a behavioural external ALU.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_arbiter_if #(.NUM_REQ(N), .WORD_SIZE(W), .ID_W(IW)) bif();

    alu_arbiter #(.NUM_REQ(N), .WORD_SIZE(W), .ID_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    // External ALU
    assign bif.alu_c = (bif.alu_mode == ALU_SUB) ?
        bif.alu_a - bif.alu_b : bif.alu_a + bif.alu_b;
    assign bif.alu_overflow = (bif.alu_mode == ALU_SUB) ?
        (bif.alu_a[W-1] != bif.alu_b[W-1] &&
         bif.alu_c[W-1] != bif.alu_a[W-1]) :
        (bif.alu_a[W-1] == bif.alu_b[W-1] &&
         bif.alu_c[W-1] != bif.alu_a[W-1]);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         m;
    } op_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  d;
        logic          o;
    } exp_t;

    op_t  dq[N][$];
    exp_t sb[$];
    logic [N-1:0] acc = '0;
    int acc_cnt = 0;
    int acc_cyc = 0;
    int rsp_cyc = 0;
    int first = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h",
                     nm, act, req);
        end
    endtask

    task automatic push(input int r,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic m,
                        input logic [W-1:0] d,
                        input logic o);
        op_t  op;
        exp_t e;
        op.a = a; op.b = b; op.m = m;
        e.id = IW'(r); e.d = d; e.o = o;
        dq[r].push_back(op);
        sb.push_back(e);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) dq[i].delete();
        sb.delete();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        clear_all();
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic drain(input string nm, input int max);
        for (int n = 0; n < max && sb.size() > 0; n++) step();
        chk({"drain_", nm}, sb.size(), 0);
    endtask

    // Requester driver: hold head op until accepted
    initial begin
        bif.req_valid = '0;
        bif.req_a     = '0;
        bif.req_b     = '0;
        bif.req_mode  = '0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < N; i++)
                if (acc[i] && dq[i].size() > 0)
                    void'(dq[i].pop_front());
            #1;
            for (int i = 0; i < N; i++) begin
                if (dq[i].size() > 0) begin
                    bif.req_valid[i]      = 1'b1;
                    bif.req_a[i*W +: W]   = dq[i][0].a;
                    bif.req_b[i*W +: W]   = dq[i][0].b;
                    bif.req_mode[i]       = dq[i][0].m;
                end else begin
                    bif.req_valid[i]      = 1'b0;
                end
            end
        end
    end

    // Monitor: handshakes observed before the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            acc = rst_n ? (bif.req_valid & bif.req_ready) : '0;
            if (|acc) begin
                acc_cnt++;
                acc_cyc = cyc;
            end
            if (rst_n && bif.rsp_valid && bif.rsp_ready) begin
                rsp_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected id=%0d data=%0h required=none",
                             bif.rsp_id, bif.rsp_data);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 32'(bif.rsp_id), 32'(e.id));
                    chk("rsp_data", 32'(bif.rsp_data), 32'(e.d));
                    chk("rsp_ovf", 32'(bif.rsp_overflow), 32'(e.o));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.rsp_ready = 1'b1;
        bif.ovf_clr   = 1'b0;
        rst_n         = 1'b0;

        // Reset values, request pending during reset
        push(0, 16'd5, 16'd7, ALU_ADD, 16'd12, 1'b0);
        step(3);
        chk("rst_rsp_valid", 32'(bif.rsp_valid), 0);
        chk("rst_rsp_data", 32'(bif.rsp_data), 0);
        chk("rst_rsp_id", 32'(bif.rsp_id), 0);
        chk("rst_rsp_ovf", 32'(bif.rsp_overflow), 0);
        chk("rst_alu_a", 32'(bif.alu_a), 0);
        chk("rst_alu_b", 32'(bif.alu_b), 0);
        chk("rst_alu_mode", 32'(bif.alu_mode), 0);
        chk("rst_sticky", 32'(bif.ovf_sticky), 0);
        chk("rst_req_ready", 32'(bif.req_ready), 0);
        rst_n = 1'b1;
        drain("single", 10);
        chk("latency", 32'(rsp_cyc - acc_cyc), 2);

        // Round-robin with all four requesters
        reset_dut();
        push(0, 16'd1, 16'd2, ALU_ADD, 16'd3, 1'b0);
        push(1, 16'd10, 16'd3, ALU_SUB, 16'd7, 1'b0);
        push(2, 16'h1234, 16'h1111, ALU_ADD, 16'h2345, 1'b0);
        push(3, 16'h00FF, 16'h0001, ALU_ADD, 16'h0100, 1'b0);
        push(0, 16'd100, 16'd200, ALU_ADD, 16'd300, 1'b0);
        push(1, 16'd0, 16'd1, ALU_SUB, 16'hFFFF, 1'b0);
        push(2, 16'd50, 16'd50, ALU_SUB, 16'd0, 1'b0);
        push(3, 16'hFFFF, 16'hFFFF, ALU_ADD, 16'hFFFE, 1'b0);
        for (int n = 0; n < 20 && sb.size() > 7; n++) step();
        first = rsp_cyc;
        drain("rr", 20);
        chk("rr_span", 32'(rsp_cyc - first), 7);
        chk("rr_sticky", 32'(bif.ovf_sticky), 0);

        // Overflow and sticky flag
        push(0, 16'h7FFF, 16'h0001, ALU_ADD, 16'h8000, 1'b1);
        drain("ovf_add", 10);
        chk("ovf_sticky_set", 32'(bif.ovf_sticky), 1);
        push(1, 16'h8000, 16'h0001, ALU_SUB, 16'h7FFF, 1'b1);
        drain("ovf_sub", 10);
        bif.ovf_clr = 1'b1;
        step();
        chk("ovf_sticky_clr", 32'(bif.ovf_sticky), 0);
        push(0, 16'h4000, 16'h4000, ALU_ADD, 16'h8000, 1'b1);
        for (int n = 0; n < 10 && !bif.rsp_valid; n++) step();
        chk("ovf_cap_valid", 32'(bif.rsp_valid), 1);
        chk("ovf_set_wins", 32'(bif.ovf_sticky), 1);
        bif.ovf_clr = 1'b0;
        drain("ovf_clr", 10);

        // Full backpressure
        reset_dut();
        bif.rsp_ready = 1'b0;
        acc_cnt = 0;
        push(0, 16'd1, 16'd1, ALU_ADD, 16'd2, 1'b0);
        push(1, 16'd10, 16'd10, ALU_ADD, 16'd20, 1'b0);
        push(0, 16'd2, 16'd2, ALU_ADD, 16'd4, 1'b0);
        push(1, 16'd20, 16'd5, ALU_SUB, 16'd15, 1'b0);
        push(0, 16'd3, 16'd3, ALU_ADD, 16'd6, 1'b0);
        step(7);
        chk("bp_accepts", 32'(acc_cnt), 2);
        chk("bp_req_ready", 32'(bif.req_ready), 0);
        chk("bp_rsp_valid", 32'(bif.rsp_valid), 1);
        chk("bp_rsp_data", 32'(bif.rsp_data), 2);
        chk("bp_rsp_id", 32'(bif.rsp_id), 0);
        chk("bp_alu_a", 32'(bif.alu_a), 10);
        bif.rsp_ready = 1'b1;
        drain("bp", 20);
        chk("bp_total", 32'(acc_cnt), 5);

        // Reset with both stages full
        bif.rsp_ready = 1'b0;
        acc_cnt = 0;
        push(0, 16'd1, 16'd2, ALU_ADD, 16'd3, 1'b0);
        push(0, 16'd3, 16'd4, ALU_ADD, 16'd7, 1'b0);
        for (int n = 0; n < 10 && acc_cnt < 2; n++) step();
        chk("mid_accepts", 32'(acc_cnt), 2);
        chk("mid_full", 32'(bif.rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rsp_valid", 32'(bif.rsp_valid), 0);
        chk("mid_rsp_data", 32'(bif.rsp_data), 0);
        chk("mid_alu_a", 32'(bif.alu_a), 0);
        chk("mid_req_ready", 32'(bif.req_ready), 0);
        clear_all();
        step(2);
        rst_n = 1'b1;
        bif.rsp_ready = 1'b1;
        step(6);
        push(0, 16'd9, 16'd1, ALU_ADD, 16'd10, 1'b0);
        push(1, 16'd20, 16'd2, ALU_ADD, 16'd22, 1'b0);
        drain("post_rst", 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single add/sub ALU between `NUM_REQ` requesters. It accepts one operation per cycle over per-requester valid/ready ports and drives registered operands into the ALU. It captures the ALU's combinational result and overflow into an output register with valid/ready backpressure. It sits between the core's operand sources (decode, address generation) and the ALU instance, which stays outside this block.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesters; legal range 2..4.
- `WORD_SIZE`, `` `WORD_SIZE `` (16), operand/result width in bits, signed two's complement.
- `ID_W`, 2, width of requester index; must satisfy 2^`ID_W` >= `NUM_REQ`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  per-requester operation valid.
- `req_ready`  out  `NUM_REQ`  per-requester accept; at most one bit high per cycle.
- `req_a`, `req_b`  in  `NUM_REQ`*`WORD_SIZE`  flattened operands; requester i uses bits [i*W +: W].
- `req_mode`  in  `NUM_REQ`  per-requester mode: 0 = ADD, 1 = SUB.
- `alu_a`, `alu_b`  out  `WORD_SIZE`  registered ALU operands.
- `alu_mode`  out  1  registered ALU mode.
- `alu_c`  in  `WORD_SIZE`  ALU result, combinational from `alu_a`/`alu_b`/`alu_mode`.
- `alu_overflow`  in  1  ALU signed-overflow flag.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accept.
- `rsp_data`  out  `WORD_SIZE`  result.
- `rsp_overflow`  out  1  overflow for `rsp_data`.
- `rsp_id`  out  `ID_W`  index of the requester that issued the result.
- `ovf_clr`  in  1  clears `ovf_sticky`.
- `ovf_sticky`  out  1  set on any captured overflow.

## Operation
- Two-stage pipeline:
  - S1: operand register (`s1_valid`, a, b, mode, id), which drives the ALU.
  - S2: result register (`rsp_*`).
- `s2_take = !rsp_valid | rsp_ready`.
- `s1_take = !s1_valid | s2_take`.
- Grant rule:
  - Round-robin over requesters with `req_valid` high.
  - Search starts at `ptr`, then `ptr+1`, and wraps modulo `NUM_REQ`.
  - `req_ready[i] = grant[i] & s1_take`; this is combinational.
  - `req_ready[i]` is never high when `req_valid[i]` is low.
- On a request handshake:
  - S1 loads the granted requester's operands, mode and id.
  - `ptr` moves to grant index + 1, with wrap.
  - `ptr` holds when there is no handshake.
- On `s1_valid & s2_take`:
  - S2 loads `alu_c`, `alu_overflow` and the S1 id.
  - `rsp_valid` is set.
- When S1 drains with no new handshake, `s1_valid` clears. `alu_a`/`alu_b`/`alu_mode` hold their last value.
- When the response handshakes and no S1 data is present, `rsp_valid` clears. `rsp_data`/`rsp_overflow`/`rsp_id` hold their last value.
- `ovf_sticky` sets when S2 loads with `alu_overflow` = 1.
  - It clears on `ovf_clr`.
  - If set and clear occur in the same cycle, set wins.
- Arithmetic wraps at `WORD_SIZE` bits. The block does no width extension and no saturation; overflow is reported only.
- Requesters must hold `req_*` stable while valid and not ready. Dropping `req_valid` before acceptance is legal and loses nothing.

## Timing
- Reset values (async on `rst_n` low): `ptr` = 0, `s1_valid` = 0, `alu_a`/`alu_b` = 0, `alu_mode` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_overflow` = 0, `rsp_id` = 0, `ovf_sticky` = 0.
- While `rst_n` is low, `req_ready` = 0 because `s1_take` is gated by the reset-synchronised enable.
- Reset mid-operation discards the S1 and S2 contents with no response.
- Latency: a request handshaked in cycle N gives `rsp_valid` high from cycle N+2 if `rsp_ready` was high. Throughput is one operation per cycle.
- Full backpressure:
  - With `rsp_valid` = 1, `rsp_ready` = 0 and `s1_valid` = 1, `req_ready` is all zero.
  - `rsp_*` and `alu_*` hold stable.
  - With S1 full, a third request waits.
- A response handshake and an S1 load in the same cycle form a simultaneous drain/fill: `rsp_valid` stays 1 with the new data.
- A single active requester is granted every cycle, regardless of `ptr`.

## Structure
- `top_macro.vh` gets `ALU_ADD` = 0 and `ALU_SUB` = 1; these replace local mode constants everywhere.
- `WORD_SIZE` stays in `top_macro.vh`.
- Sub-module `rr_arbiter`: parameterised grant logic only (inputs `req`, `ptr`; output one-hot `grant`; purely combinational). The pipeline and `ptr` register live in `alu_arbiter`.

## Test plan
- **Reset, then single request:** reset; req0 ADD a = 5, b = 7 -> `req_ready[0]` high in cycle 0; `rsp_valid` in cycle 2 with `rsp_data` = 12, `rsp_id` = 0, `rsp_overflow` = 0.
- **Round-robin fairness:** all `NUM_REQ` = 4 requesters held valid, `rsp_ready` = 1 -> grant order 0, 1, 2, 3, 0, …; one response per cycle with `rsp_id` sequence matching.
- **Overflow and sticky flag:**
  - ADD 0x7FFF + 0x0001 -> `rsp_data` = 0x8000, `rsp_overflow` = 1, `ovf_sticky` = 1.
  - SUB 0x8000 − 0x0001 -> 0x7FFF, `rsp_overflow` = 1.
  - `ovf_clr` in the same cycle as a new overflow capture -> `ovf_sticky` stays 1.
- **Backpressure:** `rsp_ready` = 0 for 5 cycles with req0/req1 valid -> exactly 2 accepted, then `req_ready` = 0 and `rsp_*` stable; release -> remaining requests complete in order with no loss or duplication.
- **Reset mid-operation:** assert `rst_n` low with S1 and S2 full -> all outputs at reset values immediately; after release, no stale response appears and `ptr` = 0.
